mine_reveal_sequencer: RTL and testbench

MINE_REVEAL_SEQUENCER -- requirements
Module: mine_reveal_sequencer

---
 rtl/mine_reveal_sequencer_pkg.sv | 18 +
 rtl/mine_reveal_sequencer_if.sv | 26 ++
 rtl/mine_reveal_sequencer_frame_delay_counter.sv | 36 +++
 rtl/mine_reveal_sequencer.sv | 108 ++++++++++
 tb/tb_mine_reveal_sequencer.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mine_reveal_sequencer_pkg.sv
// Shared board package: geometry defaults, cell-index width and sequencer state encoding.
// Used by the reveal sequencer and the mine-map and bitmap blocks.
package mine_reveal_sequencer_pkg;

  localparam int unsigned BoardWDefault = 16;
  localparam int unsigned BoardHDefault = 16;
  localparam int unsigned CellIdxW      = 8;

  typedef logic [CellIdxW-1:0] cell_idx_t;

  typedef logic [2:0] state_t;
  localparam state_t StIdle  = 3'd0;
  localparam state_t StFetch = 3'd1;
  localparam state_t StCheck = 3'd2;
  localparam state_t StWait  = 3'd3;
  localparam state_t StDone  = 3'd4;

endpackage

// File: rtl/mine_reveal_sequencer_if.sv
// Game-logic / mine-map / reveal-mask signals of the mine reveal sequencer.
// The sequencer uses the slave modport; the environment drives the master side.
interface mine_reveal_sequencer_if;
  import mine_reveal_sequencer_pkg::*;

  logic      start;
  logic      abort;
  logic      start_of_frame;
  cell_idx_t mine_rd_addr;
  logic      mine_rd_data;
  logic      reveal_we;
  cell_idx_t reveal_addr;
  logic      busy;
  logic      done;

  modport master (
    output start, abort, start_of_frame, mine_rd_data,
    input  mine_rd_addr, reveal_we, reveal_addr, busy, done
  );

  modport slave (
    input  start, abort, start_of_frame, mine_rd_data,
    output mine_rd_addr, reveal_we, reveal_addr, busy, done
  );

endinterface

// File: rtl/mine_reveal_sequencer_frame_delay_counter.sv
// Counts frame ticks after a reveal; expired_o flags the tick that completes the delay.
module mine_reveal_sequencer_frame_delay_counter #(
  parameter int unsigned FramesPerMine = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic tick_i,
  output logic expired_o
);

  localparam logic [7:0] LastCount = 8'(FramesPerMine - 1);

  logic [7:0] count_q, count_d;

  assign expired_o = tick_i && (count_q == LastCount);

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = '0;
    end else if (tick_i) begin
      // Rewind on expiry so the next reveal starts from a clean count.
      count_d = expired_o ? 8'd0 : count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mine_reveal_sequencer.sv
// Sweeps the mine map on a loss and writes each mine into the reveal mask,
// spacing consecutive reveals by a fixed number of video frames.
module mine_reveal_sequencer
  import mine_reveal_sequencer_pkg::*;
#(
  parameter int unsigned BOARD_W         = BoardWDefault,
  parameter int unsigned BOARD_H         = BoardHDefault,
  parameter int unsigned FRAMES_PER_MINE = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  mine_reveal_sequencer_if.slave mrs_io
);

  localparam int unsigned NumCells = BOARD_W * BOARD_H;
  localparam cell_idx_t   LastIdx  = cell_idx_t'(NumCells - 1);

  state_t    state_q, state_d;
  cell_idx_t idx_q, idx_d;
  logic      reveal_we;
  logic      done;
  logic      advance;
  logic      cnt_load;
  logic      cnt_tick;
  logic      cnt_expired;

  assign cnt_tick = mrs_io.start_of_frame && (state_q == StWait);

  mine_reveal_sequencer_frame_delay_counter #(
    .FramesPerMine(FRAMES_PER_MINE)
  ) u_frame_delay (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (cnt_load),
    .tick_i   (cnt_tick),
    .expired_o(cnt_expired)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    reveal_we = 1'b0;
    done      = 1'b0;
    advance   = 1'b0;
    cnt_load  = 1'b0;

    case (state_q)
      StIdle: begin
        if (mrs_io.start && !mrs_io.abort) begin
          idx_d   = '0;
          state_d = StFetch;
        end
      end
      StFetch: state_d = StCheck;
      StCheck: begin
        if (mrs_io.mine_rd_data) begin
          reveal_we = 1'b1;
          cnt_load  = 1'b1;
          state_d   = StWait;
        end else begin
          advance = 1'b1;
        end
      end
      StWait: advance = cnt_expired;
      StDone: begin
        done    = 1'b1;
        idx_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // The last cell ends the sweep instead of wrapping the index.
    if (advance) begin
      if (idx_q == LastIdx) begin
        state_d = StDone;
      end else begin
        idx_d   = idx_q + cell_idx_t'(1);
        state_d = StFetch;
      end
    end

    // Abort wins over everything; a reveal write already on the bus still goes out.
    if (mrs_io.abort && (state_q != StIdle)) begin
      state_d  = StIdle;
      idx_d    = '0;
      done     = 1'b0;
      cnt_load = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign mrs_io.mine_rd_addr = idx_q;
  assign mrs_io.reveal_addr  = idx_q;
  assign mrs_io.reveal_we    = reveal_we;
  assign mrs_io.busy         = (state_q != StIdle);
  assign mrs_io.done         = done;

endmodule

// File: tb/tb_mine_reveal_sequencer.sv
// Randomized bench for mine_reveal_sequencer: a cycle-level timeline model of the
// sweep (cell walk plus frame-pulse delays) predicts every reveal write and done.
module tb_mine_reveal_sequencer;

  localparam int NCells = 256;
  localparam int Fpm    = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mine_reveal_sequencer_if ifc ();

  mine_reveal_sequencer #(
    .BOARD_W        (16),
    .BOARD_H        (16),
    .FRAMES_PER_MINE(Fpm)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mrs_io(ifc)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int period   = 7;
  int phase    = 0;
  bit frames_en = 1'b0;
  bit mines [NCells];

  int w_addr_q[$];
  int w_cyc_q[$];
  int done_q[$];
  int pulse_q[$];
  int exp_a[$];
  int exp_c[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Mine map with one-cycle read latency.
  always @(posedge clk) ifc.mine_rd_data <= mines[ifc.mine_rd_addr];

  initial begin
    ifc.start_of_frame = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ifc.start_of_frame = frames_en && ((cyc % period) == phase);
    end
  end

  always @(negedge clk) begin
    if (ifc.reveal_we === 1'b1) begin
      w_addr_q.push_back(int'(ifc.reveal_addr));
      w_cyc_q.push_back(cyc);
    end
    if (ifc.done === 1'b1) done_q.push_back(cyc);
    if (ifc.start_of_frame === 1'b1) pulse_q.push_back(cyc);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks, required completion",
             n_checks);
    $fatal(1);
  end

  // Cycle of the Fpm-th frame pulse at or after cycle 'from', or -1 if none recorded.
  function automatic int nth_pulse(input int from);
    int seen = 0;
    foreach (pulse_q[i]) begin
      if (pulse_q[i] >= from) begin
        seen++;
        if (seen == Fpm) return pulse_q[i];
      end
    end
    return -1;
  endfunction

  // Timeline: cell j is fetched at cycle nf and checked at nf+1. A mine is written at the
  // check and the walk resumes the cycle after the Fpm-th pulse seen from nf+2 onward.
  // Returns the expected done cycle (the cycle after the last cell is finished).
  function automatic int run_model(input int s);
    int nf = s;
    int c;
    exp_a.delete();
    exp_c.delete();
    for (int j = 0; j < NCells; j++) begin
      if (mines[j]) begin
        exp_a.push_back(j);
        exp_c.push_back(nf + 1);
        c = nth_pulse(nf + 2);
        if (c < 0) return -1;
        nf = c + 1;
      end else begin
        nf += 2;
      end
    end
    return nf;
  endfunction

  task automatic clear_mon();
    w_addr_q.delete();
    w_cyc_q.delete();
    done_q.delete();
    pulse_q.delete();
  endtask

  task automatic pulse_start(output int s);
    @(posedge clk);
    #1;
    ifc.start = 1'b1;
    s = cyc + 1;
    @(posedge clk);
    #1;
    ifc.start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int busy_low, output bit seen);
    busy_low = 0;
    seen     = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (ifc.busy !== 1'b1) busy_low++;
      if (ifc.done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic wait_first_write(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (w_addr_q.size() > 0) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifc.start = 1'b0;
    ifc.abort = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (ifc.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b expected 0", ifc.busy);
    end
    n_checks++;
    if (ifc.done !== 1'b0) begin
      n_fail++; $display("FAIL reset_done: got %b expected 0", ifc.done);
    end
    n_checks++;
    if (ifc.reveal_we !== 1'b0) begin
      n_fail++; $display("FAIL reset_reveal_we: got %b expected 0", ifc.reveal_we);
    end
    n_checks++;
    if (ifc.reveal_addr !== 8'd0) begin
      n_fail++; $display("FAIL reset_reveal_addr: got %0d expected 0", ifc.reveal_addr);
    end
    n_checks++;
    if (ifc.mine_rd_addr !== 8'd0) begin
      n_fail++; $display("FAIL reset_mine_rd_addr: got %0d expected 0", ifc.mine_rd_addr);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    frames_en = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (ifc.busy !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_busy: got %b expected 0", ifc.busy);
    end
  endtask

  task automatic test_empty_sweep();
    int s, busy_low, dn;
    bit seen;
    foreach (mines[i]) mines[i] = 1'b0;
    clear_mon();
    pulse_start(s);
    wait_done(3000, busy_low, seen);
    repeat (20) @(negedge clk);
    dn = (done_q.size() > 0) ? done_q[0] - s : -1;
    n_checks++;
    if (dn != 2 * NCells) begin
      n_fail++; $display("FAIL empty_done_latency: got %0d expected %0d", dn, 2 * NCells);
    end
    n_checks++;
    if (w_addr_q.size() != 0) begin
      n_fail++; $display("FAIL empty_writes: got %0d expected 0", w_addr_q.size());
    end
    n_checks++;
    if (busy_low != 0) begin
      n_fail++; $display("FAIL empty_busy_low_cycles: got %0d expected 0", busy_low);
    end
    n_checks++;
    if (done_q.size() != 1) begin
      n_fail++; $display("FAIL empty_done_count: got %0d expected 1", done_q.size());
    end
  endtask

  // Iteration 0 is the fixed 0/17/255 map; the rest are random maps and frame rates.
  task automatic test_sweeps();
    int s, busy_low, de, k;
    bit seen;
    for (int it = 0; it < 4; it++) begin
      foreach (mines[i]) mines[i] = 1'b0;
      if (it == 0) begin
        mines[0] = 1'b1; mines[17] = 1'b1; mines[255] = 1'b1;
        period = 5; phase = 0;
      end else begin
        k = $urandom_range(1, 10);
        for (int m = 0; m < k; m++) mines[$urandom_range(0, NCells - 1)] = 1'b1;
        period = $urandom_range(1, 9);
        phase  = $urandom_range(0, period - 1);
      end
      clear_mon();
      pulse_start(s);
      wait_done(3000, busy_low, seen);
      repeat (20) @(negedge clk);
      de = run_model(s);
      n_checks++;
      if (done_q.size() != 1) begin
        n_fail++; $display("FAIL sweep%0d_done_count: got %0d expected 1", it, done_q.size());
      end
      n_checks++;
      if (done_q.size() > 0 && done_q[0] != de) begin
        n_fail++; $display("FAIL sweep%0d_done_cycle: got %0d expected %0d", it, done_q[0], de);
      end
      n_checks++;
      if (busy_low != 0) begin
        n_fail++; $display("FAIL sweep%0d_busy_low_cycles: got %0d expected 0", it, busy_low);
      end
      n_checks++;
      if (w_addr_q.size() != exp_a.size()) begin
        n_fail++;
        $display("FAIL sweep%0d_write_count: got %0d expected %0d", it, w_addr_q.size(),
                 exp_a.size());
      end
      for (int i = 0; i < w_addr_q.size() && i < exp_a.size(); i++) begin
        n_checks++;
        if (w_addr_q[i] != exp_a[i] || w_cyc_q[i] != exp_c[i]) begin
          n_fail++;
          $display("FAIL sweep%0d_write%0d: got addr %0d cyc %0d expected addr %0d cyc %0d",
                   it, i, w_addr_q[i], w_cyc_q[i], exp_a[i], exp_c[i]);
        end
      end
    end
  endtask

  task automatic test_abort_wait();
    int s, busy_hi;
    bit seen;
    foreach (mines[i]) mines[i] = 1'b0;
    mines[5] = 1'b1;
    period = 20; phase = 0;
    clear_mon();
    pulse_start(s);
    wait_first_write(200, seen);
    repeat (3) @(posedge clk);
    #1;
    ifc.abort = 1'b1;
    @(posedge clk);
    #1;
    ifc.abort = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ifc.busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_wait_busy: got %b expected 0", ifc.busy);
    end
    busy_hi = 0;
    repeat (700) begin
      @(negedge clk);
      if (ifc.busy !== 1'b0) busy_hi++;
    end
    n_checks++;
    if (w_addr_q.size() != 1) begin
      n_fail++; $display("FAIL abort_wait_writes: got %0d expected 1", w_addr_q.size());
    end
    n_checks++;
    if (done_q.size() != 0) begin
      n_fail++; $display("FAIL abort_wait_done: got %0d expected 0", done_q.size());
    end
    n_checks++;
    if (busy_hi != 0) begin
      n_fail++; $display("FAIL abort_wait_idle_busy: got %0d expected 0", busy_hi);
    end

    // Abort landing exactly on the reveal cycle of cell 3 (checked at s+7).
    foreach (mines[i]) mines[i] = 1'b0;
    mines[3] = 1'b1;
    clear_mon();
    pulse_start(s);
    while (cyc < s + 7) begin
      @(posedge clk);
      #1;
    end
    ifc.abort = 1'b1;
    @(posedge clk);
    #1;
    ifc.abort = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ifc.busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_on_write_busy: got %b expected 0", ifc.busy);
    end
    repeat (100) @(negedge clk);
    n_checks++;
    if (w_addr_q.size() != 1 || (w_addr_q.size() == 1 && (w_addr_q[0] != 3 || w_cyc_q[0] != s + 7)))
      begin
      n_fail++;
      $display("FAIL abort_on_write_emit: got %0d writes expected 1 write of cell 3 at cyc %0d",
               w_addr_q.size(), s + 7);
    end
    n_checks++;
    if (done_q.size() != 0) begin
      n_fail++; $display("FAIL abort_on_write_done: got %0d expected 0", done_q.size());
    end
  endtask

  task automatic test_back_to_back_start();
    int s, busy_low, de;
    bit seen, hit;
    foreach (mines[i]) mines[i] = 1'b0;
    mines[12] = 1'b1; mines[40] = 1'b1; mines[200] = 1'b1;
    period = 3; phase = 1;
    clear_mon();
    pulse_start(s);
    hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(negedge clk);
      if (ifc.mine_rd_addr === 8'd40) hit = 1'b1;
    end
    n_checks++;
    if (!hit) begin
      n_fail++; $display("FAIL restart_reach_idx40: got timeout expected mine_rd_addr 40");
    end
    @(posedge clk);
    #1;
    ifc.start = 1'b1;
    @(posedge clk);
    #1;
    ifc.start = 1'b0;
    wait_done(3000, busy_low, seen);
    repeat (20) @(negedge clk);
    de = run_model(s);
    n_checks++;
    if (done_q.size() != 1) begin
      n_fail++; $display("FAIL restart_done_count: got %0d expected 1", done_q.size());
    end
    n_checks++;
    if (done_q.size() > 0 && done_q[0] != de) begin
      n_fail++; $display("FAIL restart_done_cycle: got %0d expected %0d", done_q[0], de);
    end
    n_checks++;
    if (w_addr_q.size() != exp_a.size()) begin
      n_fail++;
      $display("FAIL restart_writes: got %0d expected %0d", w_addr_q.size(), exp_a.size());
    end
  endtask

  task automatic test_reset_mid_wait();
    int s, busy_hi;
    bit seen;
    foreach (mines[i]) mines[i] = 1'b0;
    mines[5] = 1'b1;
    period = 20; phase = 3;
    clear_mon();
    pulse_start(s);
    wait_first_write(200, seen);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({ifc.busy, ifc.done, ifc.reveal_we, ifc.reveal_addr, ifc.mine_rd_addr} !== 19'd0) begin
        n_fail++;
        $display("FAIL mid_reset_outputs%0d: got busy %b done %b we %b raddr %0d maddr %0d expected all 0",
                 i, ifc.busy, ifc.done, ifc.reveal_we, ifc.reveal_addr, ifc.mine_rd_addr);
      end
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    busy_hi = 0;
    repeat (600) begin
      @(negedge clk);
      if (ifc.busy !== 1'b0) busy_hi++;
    end
    n_checks++;
    if (busy_hi != 0) begin
      n_fail++; $display("FAIL after_reset_busy: got %0d expected 0", busy_hi);
    end
    n_checks++;
    if (done_q.size() != 0 || w_addr_q.size() != 1) begin
      n_fail++;
      $display("FAIL after_reset_activity: got %0d done %0d writes expected 0 done 1 write",
               done_q.size(), w_addr_q.size());
    end
  endtask

  task automatic test_start_abort_same_cycle();
    int bad;
    clear_mon();
    @(posedge clk);
    #1;
    ifc.start = 1'b1;
    ifc.abort = 1'b1;
    @(posedge clk);
    #1;
    ifc.start = 1'b0;
    ifc.abort = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (ifc.busy !== 1'b0 || ifc.mine_rd_addr !== 8'd0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL start_abort_idle: got %0d active cycles expected 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_empty_sweep();
    test_sweeps();
    test_abort_wait();
    test_back_to_back_start();
    test_reset_mid_wait();
    test_start_abort_same_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
